// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
//   Shared types, defaults and the rotate-priority pick function for the
//   round-robin mux arbiter.
//   Optional feature macro used by the files that import this package:
//   MUX_RR_ARBITER_LOCK_EN (adds per-requester lock support).
package mux_rr_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DATA_W  = 8;

    // Upper bound on requesters handled by rr_pick; callers zero-extend.
    localparam int unsigned PICK_MAX_REQ = 32;
    localparam int unsigned PICK_IDX_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,  // output register empty
        HOLD = 1'b1   // output register holds a word
    } arb_state_t;

    typedef struct packed {
        logic                  found;
        logic [PICK_IDX_W-1:0] index;
    } pick_t;

    // First set bit of valid, scanning ptr, ptr+1, ... wrapping at num_req.
    // ptr must be < num_req and num_req <= PICK_MAX_REQ.
    function automatic pick_t rr_pick(input logic [PICK_MAX_REQ-1:0] valid,
                                      input int unsigned             ptr,
                                      input int unsigned             num_req);
        pick_t       r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < PICK_MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if ((k < num_req) && !r.found && valid[idx[PICK_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.index = idx[PICK_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//   Requester-side and consumer-side handshake bundle of the round-robin
//   mux arbiter.
//   Signals:
//     req_valid [NUM_REQ]         per-requester valid
//     req_data  [NUM_REQ*DATA_W]  packed words, requester i at [i*DATA_W +: DATA_W]
//     req_ready [NUM_REQ]         one-hot (or zero) accept strobe
//     req_lock  [NUM_REQ]         only when MUX_RR_ARBITER_LOCK_EN is defined
//     out_valid / out_data / out_ready   registered output handshake
//     mux_sel   [SEL_W]           index of requester whose word is in out_data
//     busy                        out_valid || any req_valid
//   Modports: slave = arbiter side, master = requesters/consumer side.
interface mux_rr_arbiter_if
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W
);
    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_ready;
    logic [SEL_W-1:0]          mux_sel;
    logic                      busy;

`ifdef MUX_RR_ARBITER_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;

    modport slave (
        input  req_valid, req_data, req_lock, out_ready,
        output req_ready, out_valid, out_data, mux_sel, busy
    );

    modport master (
        output req_valid, req_data, req_lock, out_ready,
        input  req_ready, out_valid, out_data, mux_sel, busy
    );
`else
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, mux_sel, busy
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, mux_sel, busy
    );
`endif

endinterface

// File: rtl/mux_rr_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Combinational rotate-priority encoder: returns the first valid requester
//   at or after ptr (wrapping), as both a one-hot grant and an index.
//   Ports:
//     valid [NUM_REQ]  candidate requesters
//     ptr   [SEL_W]    highest-priority position this cycle
//     grant [NUM_REQ]  one-hot of the pick, zero when nothing is valid
//     found            any candidate valid
//     idx   [SEL_W]    index of the pick (meaningful only when found)
module rr_priority_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    logic [PICK_MAX_REQ-1:0] valid_ext;
    pick_t                   pick;

    always_comb begin
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = valid;
        pick                   = rr_pick(valid_ext, 32'(ptr), NUM_REQ);
        found                  = pick.found;
        idx                    = pick.index[SEL_W-1:0];
        grant                  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant[i] = pick.found && (pick.index == PICK_IDX_W'(i));
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter/sequencer for a shared N:1 mux datapath. Picks one of
//   NUM_REQ valid/ready requesters per transfer, drives the mux select and
//   registers the selected word into a 1-deep output stage.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   mux_rr_arbiter_if.slave (requester and consumer handshakes)
//   Optional feature: define MUX_RR_ARBITER_LOCK_EN to add bus.req_lock.
//   An accept with req_lock[i]=1 pins arbitration to requester i until an
//   accept from i with req_lock[i]=0; the fairness pointer only moves on
//   that unlocking accept.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    logic [DATA_W-1:0]  words [NUM_REQ];
    logic [NUM_REQ-1:0] pick_valid;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   ptr_after_pick;
    logic               can_load;
    logic               accept;

`ifdef MUX_RR_ARBITER_LOCK_EN
    logic               lock_q, lock_d;
    logic [SEL_W-1:0]   lock_idx_q, lock_idx_d;
`endif

    // Unpack requester words for the select mux.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            words[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // While locked, only the lock owner is a candidate.
    always_comb begin
        pick_valid = bus.req_valid;
`ifdef MUX_RR_ARBITER_LOCK_EN
        if (lock_q) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (SEL_W'(i) != lock_idx_q) begin
                    pick_valid[i] = 1'b0;
                end
            end
        end
`endif
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (pick_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        can_load       = (state_q == IDLE) || bus.out_ready;
        accept         = can_load && pick_found && !rst;
        ptr_after_pick = (pick_idx == SEL_W'(NUM_REQ - 1)) ? '0 : pick_idx + SEL_W'(1);

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        mux_sel_d  = mux_sel_q;
        out_data_d = out_data_q;
`ifdef MUX_RR_ARBITER_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
`endif

        if (accept) begin
            state_d    = HOLD;
            mux_sel_d  = pick_idx;
            out_data_d = words[pick_idx];
`ifdef MUX_RR_ARBITER_LOCK_EN
            lock_d     = bus.req_lock[pick_idx];
            lock_idx_d = pick_idx;
            if (!bus.req_lock[pick_idx]) begin
                rr_ptr_d = ptr_after_pick;
            end
`else
            rr_ptr_d   = ptr_after_pick;
`endif
        end else if (bus.out_ready) begin
            // Output drained and nothing new: data/select keep their last value.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            mux_sel_q  <= '0;
            out_data_q <= '0;
`ifdef MUX_RR_ARBITER_LOCK_EN
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            mux_sel_q  <= mux_sel_d;
            out_data_q <= out_data_d;
`ifdef MUX_RR_ARBITER_LOCK_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign bus.req_ready = accept ? pick_grant : '0;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.busy      = (state_q == HOLD) || (|bus.req_valid);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Directed scenarios plus randomized traffic against a behavioural model
//   of the round-robin arbiter (pointer, pick-by-scan, 1-deep output).
//   Honours MUX_RR_ARBITER_LOCK_EN for the lock feature.
module tb_mux_rr_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
`ifdef MUX_RR_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    mux_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Behavioural model state
    bit          m_ov;
    logic [DW-1:0] m_od;
    int          m_sel;
    int          m_ptr;
    bit          m_lock;
    int          m_lock_idx;

    localparam logic [N*DW-1:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_ov       = 1'b0;
        m_od       = '0;
        m_sel      = 0;
        m_ptr      = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
    endfunction

    // Round-robin choice: first valid requester scanning from the pointer.
    function automatic int model_pick(input logic [N-1:0] v);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (v[i] && (!m_lock || i == m_lock_idx)) return i;
        end
        return -1;
    endfunction

    // One clock: apply inputs, check the DUT against the model, advance the model.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                        input logic ordy, input logic [N-1:0] lk);
        int         p;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = ordy;
`ifdef MUX_RR_ARBITER_LOCK_EN
        bus.req_lock  = lk;
`endif
        #1;
        p       = model_pick(v);
        exp_rdy = '0;
        if (!r && (!m_ov || ordy) && p >= 0) exp_rdy[p] = 1'b1;
        check_eq("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check_eq("out_valid", 64'(bus.out_valid), 64'(m_ov));
        check_eq("out_data",  64'(bus.out_data),  64'(m_od));
        check_eq("mux_sel",   64'(bus.mux_sel),   64'(m_sel));
        check_eq("busy",      64'(bus.busy),      64'(m_ov || (|v)));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (exp_rdy != '0) begin
            m_ov  = 1'b1;
            m_od  = d[p*DW +: DW];
            m_sel = p;
            if (!(LOCK_EN && lk[p])) m_ptr = (p + 1) % N;
            m_lock     = LOCK_EN && lk[p];
            m_lock_idx = p;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0]    rv;
        logic [N*DW-1:0] rd;
        logic            ro;
        logic [N-1:0]    rl;

        bus.req_valid = '1;
        bus.req_data  = DATA_A;
        bus.out_ready = 1'b1;
`ifdef MUX_RR_ARBITER_LOCK_EN
        bus.req_lock  = '0;
`endif
        model_reset();
        @(posedge clk);

        // Reset held two cycles with every requester valid.
        repeat (2) step(1'b1, '1, DATA_A, 1'b1, '0);

        // Fairness: A0, A1, A2, A3, A0.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '1, DATA_A, 1'b1, '0);
            #1 check_eq("fair_word", 64'(bus.out_data), 64'(8'hA0 + k % 4));
        end

        // Stall on A1, then release to A2.
        step(1'b1, '1, DATA_A, 1'b1, '0);
        step(1'b0, '1, DATA_A, 1'b1, '0);
        step(1'b0, '1, DATA_A, 1'b1, '0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '1, DATA_A, 1'b0, '0);
            #1 check_eq("stall_word", 64'(bus.out_data), 64'(8'hA1));
            check_eq("stall_ready", 64'(bus.req_ready), 64'(0));
        end
        step(1'b0, '1, DATA_A, 1'b1, '0);
        #1 check_eq("release_word", 64'(bus.out_data), 64'(8'hA2));

        // Skip and wrap from pointer 3.
        step(1'b0, 4'b0011, DATA_A, 1'b1, '0);
        #1 check_eq("skip_sel0", 64'(bus.mux_sel), 64'(0));
        step(1'b0, 4'b0011, DATA_A, 1'b1, '0);
        #1 check_eq("skip_sel1", 64'(bus.mux_sel), 64'(1));
        step(1'b0, 4'b1000, DATA_A, 1'b1, '0);
        #1 check_eq("wrap_sel3", 64'(bus.mux_sel), 64'(3));
        step(1'b0, 4'b1111, DATA_A, 1'b1, '0);
        #1 check_eq("wrap_sel0", 64'(bus.mux_sel), 64'(0));

        // Sparse: only requester 2, granted every cycle.
        step(1'b1, '0, DATA_A, 1'b1, '0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0100, DATA_A, 1'b1, '0);
            #1 check_eq("sparse_sel", 64'(bus.mux_sel), 64'(2));
            check_eq("sparse_valid", 64'(bus.out_valid), 64'(1));
            check_eq("sparse_ready", 64'(bus.req_ready), 64'(4'b0100));
        end

`ifdef MUX_RR_ARBITER_LOCK_EN
        // Lock: pointer at 1, requester 1 holds the mux for 3 words, then 2.
        step(1'b1, '0, DATA_A, 1'b1, '0);
        step(1'b0, 4'b0001, DATA_A, 1'b1, '0);
        step(1'b0, 4'b0111, DATA_A, 1'b1, 4'b0010);
        #1 check_eq("lock_sel_a", 64'(bus.mux_sel), 64'(1));
        step(1'b0, 4'b0111, DATA_A, 1'b1, 4'b0010);
        #1 check_eq("lock_sel_b", 64'(bus.mux_sel), 64'(1));
        step(1'b0, 4'b0111, DATA_A, 1'b1, 4'b0000);
        #1 check_eq("lock_sel_c", 64'(bus.mux_sel), 64'(1));
        step(1'b0, 4'b0111, DATA_A, 1'b1, 4'b0000);
        #1 check_eq("unlock_sel", 64'(bus.mux_sel), 64'(2));
`endif

        // Randomized traffic with occasional resets, stalls and lock requests.
        for (int k = 0; k < 400; k++) begin
            rv = N'($urandom);
            rd = (N*DW)'($urandom);
            ro = ($urandom_range(0, 3) != 0);
            rl = N'($urandom & $urandom);
            step(($urandom_range(0, 31) == 0), rv, rd, ro, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
